seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Sequential restoring (shift-subtract) unsigned divider.
//  It is the inverse datapath of the sequential shift-add multiplier.
//  It takes a WIDTH_ACC-bit dividend and divisor and produces the quotient and remainder
//  after WIDTH_ACC iteration cycles, one quotient bit per clock.
//  It sits beside the multiplier in the arithmetic unit and uses the same start/busy/done handshake.
// PARAMETERS
//  WIDTH_ACC  5   operand width: dividend, divisor, quotient and remainder
//  WIDTH      11  packed result width (2*WIDTH_ACC+1): {div_zero, remainder, quotient}
// PORTS
//  clk        in   1          rising-edge clock, the single clock domain
//  rst        in   1          synchronous, active-high reset
//  start      in   1          request a divide; sampled only in IDLE
//  dividend   in   WIDTH_ACC  numerator; captured on the accepting edge
//  divisor    in   WIDTH_ACC  denominator; captured on the accepting edge
//  busy       out  1          high while iterating (CALC)
//  done       out  1          one-cycle pulse: results valid
//  quotient   out  WIDTH_ACC  registered quotient
//  remainder  out  WIDTH_ACC  registered remainder
//  div_zero   out  1          high when the last accepted divisor was 0
//  DO         out  WIDTH      {div_zero, remainder, quotient}
// BEHAVIOUR
//  Reset: clock and reset are fixed as above (one clock; rst synchronous, active-high).
//   On rst at a clock edge: state=IDLE; busy, done, div_zero = 0; quotient, remainder, DO = 0.
//   rst has priority over start at the same edge.
//   rst mid-CALC aborts the operation; done does not pulse.
//  States: IDLE, CALC, DONE.
//   IDLE -> CALC when start=1 and divisor!=0.
//   IDLE -> DONE when start=1 and divisor==0.
//   CALC -> DONE after WIDTH_ACC iterations.
//   DONE -> IDLE unconditionally after one cycle.
//  Accept edge (E0), divisor != 0:
//   Latch: Q = dividend; D = divisor; R = 0, where R is WIDTH_ACC+1 bits.
//   Set count=0 and busy=1.
//  Each CALC edge:
//   {R,Q} = {R,Q} << 1.
//   T = R - {1'b0,D}.
//   If T[MSB]==0: R = T and Q[0] = 1; otherwise Q[0] = 0.
//   count++.
//  At the edge completing iteration WIDTH_ACC (edge E0+WIDTH_ACC):
//   state=DONE; busy=0; done=1.
//   quotient=Q; remainder=R[WIDTH_ACC-1:0]; div_zero=0.
//  Latency: done is high during the cycle after edge E0+WIDTH_ACC, i.e. 5 cycles at the default.
//   done clears at the next edge.
//  Divide by zero (divisor==0 at accept):
//   No iterations; busy stays 0.
//   At E0: state=DONE; done=1.
//   quotient = all ones; remainder = dividend; div_zero=1.
//  Outputs quotient, remainder, div_zero and DO hold their values until the next completed operation.
//  start while busy or in DONE is ignored; no queuing.
//   start held high re-triggers on the first IDLE cycle.
//  dividend and divisor changing after E0 have no effect.
//  Arithmetic: the R and T subtraction is WIDTH_ACC+1 bits wide; its MSB is the borrow.
//   The result is always quotient*divisor + remainder == dividend, with remainder < divisor.
// TESTING
//  1. Reset, then 23/5: start at E0 -> busy for 5 edges.
//     Next cycle: done=1, quotient=4, remainder=3, div_zero=0, DO=11'b0_00011_00100.
//  2. Extremes: 31/1 -> q=31, r=0. 7/9 -> q=0, r=7. 31/31 -> q=1, r=0.
//  3. 13/0 -> done one cycle after E0, busy never high, q=31, r=13, div_zero=1.
//     Then 12/4 -> q=3, r=0, div_zero=0.
//  4. 23/5 started; pulse start with 30/2 at E0+2 -> ignored.
//     Result stays q=4, r=3; exactly one done pulse.
//  5. 23/5 started; rst at E0+3 -> busy=0 and done=0 next cycle, outputs 0, no done pulse.
//     Then 29/4 -> q=7, r=1.
//  6. Exhaustive sweep of all 32x32 operand pairs, one start per done:
//     q and r match dividend/divisor and dividend%divisor, divisor 0 handled per rule 3.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Sequential restoring (shift-subtract) unsigned divider.
// One quotient bit is produced per clock while in CALC. Divide-by-zero
// finishes in a single cycle with an all-ones quotient and the dividend as
// remainder. Results are held in output registers until the next completed
// operation; start is only honoured in IDLE.
module seq_restoring_divider #(
    parameter int WIDTH_ACC = 5,
    parameter int WIDTH     = 2 * WIDTH_ACC + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH_ACC-1:0] dividend,
    input  logic [WIDTH_ACC-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH_ACC-1:0] quotient,
    output logic [WIDTH_ACC-1:0] remainder,
    output logic                 div_zero,
    output logic [WIDTH-1:0]     DO
);

    localparam int CNT_W = $clog2(WIDTH_ACC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;

    // Working registers. The partial remainder after each restore step is
    // always smaller than the divisor, so its top bit is known to be zero
    // and only WIDTH_ACC bits are stored; the shifted value is widened to
    // WIDTH_ACC+1 bits before the subtraction so the MSB acts as the borrow.
    logic [WIDTH_ACC-1:0] q_q, q_d;
    logic [WIDTH_ACC-1:0] d_q, d_d;
    logic [WIDTH_ACC-1:0] r_q, r_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Result registers, held until the next completed operation.
    logic [WIDTH_ACC-1:0] quotient_q, quotient_d;
    logic [WIDTH_ACC-1:0] remainder_q, remainder_d;
    logic                 div_zero_q, div_zero_d;

    // One iteration of the restoring datapath.
    logic [WIDTH_ACC:0]   r_shift;
    logic [WIDTH_ACC:0]   trial;
    logic                 borrow;
    logic [WIDTH_ACC-1:0] q_iter;
    logic [WIDTH_ACC-1:0] r_iter;
    logic                 last_iter;

    // Shift {R,Q} left by one, trial-subtract the divisor, restore on borrow.
    always_comb begin
        r_shift   = {r_q, q_q[WIDTH_ACC-1]};
        trial     = r_shift - {1'b0, d_q};
        borrow    = trial[WIDTH_ACC];
        if (WIDTH_ACC > 1) begin
            q_iter = {q_q[WIDTH_ACC-2:0], ~borrow};
        end else begin
            q_iter = ~borrow;
        end
        r_iter    = borrow ? r_shift[WIDTH_ACC-1:0] : trial[WIDTH_ACC-1:0];
        last_iter = (count_q == CNT_W'(WIDTH_ACC - 1));
    end

    // Next-state and datapath control for the IDLE/CALC/DONE controller.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        count_d = '0;
                        state_d = CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        state_d     = DONE;
                    end
                end
            end

            CALC: begin
                q_d     = q_iter;
                r_d     = r_iter;
                count_d = count_q + CNT_W'(1);
                if (last_iter) begin
                    quotient_d  = q_iter;
                    remainder_d = r_iter;
                    div_zero_d  = 1'b0;
                    state_d     = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the values from before this edge.
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign DO        = {div_zero_q, remainder_q, quotient_q};

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed scenarios, random
// operations and an exhaustive operand sweep against an arithmetic model.
module tb_seq_restoring_divider;

    localparam int W  = 5;
    localparam int WD = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_zero;
    logic [WD-1:0] DO;

    int n_checks = 0;
    int n_errors = 0;

    seq_restoring_divider #(.WIDTH_ACC(W), .WIDTH(WD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .DO        (DO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: {div_zero, remainder, quotient} from plain integer arithmetic.
    function automatic logic [WD-1:0] ref_model(input int a, input int b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) begin
            q = '1;
            r = W'(a);
            return {1'b1, r, q};
        end
        q = W'(a / b);
        r = W'(a % b);
        return {1'b0, r, q};
    endfunction

    // Starts one operation from IDLE (called just after a falling edge),
    // waits for done with a bound, and checks timing and results.
    task automatic run_op(input int a, input int b, input string tag);
        logic [WD-1:0] exp;
        int lat;
        int busy_cnt;
        exp      = ref_model(a, b);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        // Operand changes after the accepting edge must not matter.
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 4 * W) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), (b == 0) ? 32'd0 : 32'(W));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), (b == 0) ? 32'd0 : 32'(W));
        check({tag, "_quotient"}, 32'(quotient), 32'(exp[W-1:0]));
        check({tag, "_remainder"}, 32'(remainder), 32'(exp[2*W-1:W]));
        check({tag, "_div_zero"}, 32'(div_zero), 32'(exp[WD-1]));
        check({tag, "_DO"}, 32'(DO), 32'(exp));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        check("rst_DO", 32'(DO), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic case and extremes.
        run_op(23, 5, "t23_5");
        check("t23_5_DO_literal", 32'(DO), 32'(11'b0_00011_00100));
        run_op(31, 1, "t31_1");
        run_op(7, 9, "t7_9");
        run_op(31, 31, "t31_31");

        // Divide by zero, then a normal operation clears div_zero.
        run_op(13, 0, "t13_0");
        run_op(12, 4, "t12_4");

        // start while busy is ignored; exactly one done pulse.
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        dividend = 5'd30;
        divisor  = 5'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        repeat (3 * W) begin
            if (done) begin
                done_cnt++;
                check("busy_start_quotient", 32'(quotient), 32'd4);
                check("busy_start_remainder", 32'(remainder), 32'd3);
            end
            @(negedge clk);
        end
        check("busy_start_done_count", 32'(done_cnt), 32'd1);

        // Reset in the middle of CALC aborts without a done pulse.
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_DO", 32'(DO), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (2 * W) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(29, 4, "t29_4");

        // Random operations with random idle gaps.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), "rand");
        end

        // Exhaustive sweep of all operand pairs.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                run_op(a, b, "sweep");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
